passwd_checker: RTL
===================

PASSWD_CHECKER -- requirements
Module: passwd_checker

Interface
REQ-001 Parameter OPEN_CYCLES, default 50_000_000, unlock hold time in clk cycles (>=1).
REQ-002 Parameter LOCK_CYCLES, default 500_000_000, lockout duration in clk cycles (>=1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 key_valid  input  1  one-cycle strobe, key_val holds an entered digit.
REQ-006 key_val  input  4  entered digit, BCD 0-9.
REQ-007 key_confirm  input  1  one-cycle strobe, submit entry.
REQ-008 key_cancel  input  1  one-cycle strobe, abandon entry.
REQ-009 q1..q6  input  4 each  stored password digits from the password register; q1 is the first digit entered.
REQ-010 unlock  output  1  registered, high while lock is open.
REQ-011 alarm  output  1  registered, high during lockout.
REQ-012 err_cnt  output  2  consecutive failed attempts, saturating at 3.
REQ-013 digit_cnt  output  3  digits accepted in the current entry, 0-6.
REQ-014 busy  output  1  high in OPEN or LOCKOUT; all keys ignored.

Function
REQ-015 FSM states: IDLE, ENTRY, OPEN, LOCKOUT.
REQ-016 Each accepted digit SHALL be compared at its accept edge with q[digit_cnt+1]; any inequality SHALL set an internal mismatch flag held until the entry ends; entered digits SHALL NOT be stored.
REQ-017 key_val > 9 SHALL count as a digit and set mismatch.
REQ-018 In IDLE, key_valid SHALL accept digit 1 and move to ENTRY with digit_cnt=1; key_confirm and key_cancel in IDLE SHALL be ignored.
REQ-019 In ENTRY, key_valid with digit_cnt<6 SHALL increment digit_cnt; with digit_cnt=6 SHALL set mismatch and leave digit_cnt at 6.
REQ-020 Same-cycle priority: key_cancel > key_confirm > key_valid; the lower-priority strobe SHALL be dropped.
REQ-021 key_cancel in ENTRY SHALL return to IDLE, clear digit_cnt and mismatch, and leave err_cnt unchanged.
REQ-022 key_confirm in ENTRY with digit_cnt=6 and no mismatch SHALL, at that edge, enter OPEN, set unlock=1, clear err_cnt, digit_cnt and mismatch.
REQ-023 Any other key_confirm in ENTRY, including digit_cnt<6, is a failure: err_cnt SHALL increment (saturating at 3), digit_cnt and mismatch SHALL clear, and the next state SHALL be IDLE (or LOCKOUT per REQ-029).
REQ-024 OPEN SHALL last exactly OPEN_CYCLES cycles with unlock=1, then return to IDLE with unlock=0 on the same edge.
REQ-025 q1..q6 SHALL be stable during ENTRY; a change mid-entry affects only digits accepted after it.

Reset
REQ-026 While clr=0: state=IDLE, unlock=0, alarm=0, err_cnt=0, digit_cnt=0, busy=0, mismatch=0, all timers=0, independent of clk.
REQ-027 Reset asserted mid-OPEN or mid-LOCKOUT SHALL abort immediately; after release the block SHALL be in IDLE with no residual timer count.
REQ-028 The first accepted key SHALL be on the first rising clk edge after clr deasserts.

Configuration
REQ-029 With ALARM_LOCKOUT_EN defined: a failure that makes err_cnt reach 3 SHALL enter LOCKOUT with alarm=1 for exactly LOCK_CYCLES cycles; exit SHALL clear alarm and err_cnt and return to IDLE.
REQ-030 Without ALARM_LOCKOUT_EN: LOCKOUT and its timer SHALL not be built, alarm SHALL be constant 0, err_cnt SHALL saturate at 3 until a successful unlock or reset, and entry SHALL remain available.

Verification (q1..q6=1,2,3,4,5,6; OPEN_CYCLES=4; LOCK_CYCLES=8)
REQ-031 Enter 1,2,3,4,5,6 then confirm -> unlock=1 from the confirm edge for 4 cycles, busy=1, err_cnt=0, then IDLE.
REQ-032 Enter 1,2,3,4,5,7 then confirm -> unlock stays 0, err_cnt=1, digit_cnt=0, IDLE.
REQ-033 Enter 1,2,3, then cancel and confirm in the same cycle -> cancel wins, err_cnt unchanged, digit_cnt=0.
REQ-034 Three wrong entries with ALARM_LOCKOUT_EN -> alarm=1 for 8 cycles, keys ignored, then err_cnt=0; without the macro -> alarm=0, err_cnt=3, correct code still unlocks.
REQ-035 Enter 1,2,3,4,5,6,6 then confirm -> failure, err_cnt=1; confirm after 5 digits -> failure.
REQ-036 Assert clr at cycle 2 of OPEN -> unlock=0 immediately, all outputs at reset values, next correct entry unlocks normally.

Source files
------------

// File: rtl/passwd_checker.sv
// Six-digit keypad password checker: IDLE/ENTRY/OPEN/LOCKOUT FSM with timed unlock.
// Define ALARM_LOCKOUT_EN to build the three-strike LOCKOUT state and its alarm timer.
module passwd_checker #(
  parameter int unsigned OPEN_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  input  logic       key_confirm,
  input  logic       key_cancel,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  input  logic [3:0] q4,
  input  logic [3:0] q5,
  input  logic [3:0] q6,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] err_cnt,
  output logic [2:0] digit_cnt,
  output logic       busy
);

`ifdef ALARM_LOCKOUT_EN
  localparam int unsigned MAXC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
`else
  localparam int unsigned MAXC = OPEN_CYCLES;
`endif
  localparam int unsigned TW = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      err_q, err_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            mism_q, mism_d;
  logic            unlock_q, unlock_d;
  logic [3:0]      exp_digit;
  logic            digit_bad;
  logic [1:0]      err_inc;
`ifdef ALARM_LOCKOUT_EN
  logic            alarm_q, alarm_d;
`endif

  // Stored digit that the next accepted key must match.
  always_comb begin
    case (cnt_q)
      3'd0:    exp_digit = q1;
      3'd1:    exp_digit = q2;
      3'd2:    exp_digit = q3;
      3'd3:    exp_digit = q4;
      3'd4:    exp_digit = q5;
      default: exp_digit = q6;
    endcase
  end

  assign digit_bad = (key_val > 4'd9) || (key_val != exp_digit) || (cnt_q == 3'd6);
  assign err_inc   = (err_q == 2'd3) ? 2'd3 : err_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    mism_d   = mism_q;
    unlock_d = unlock_q;
`ifdef ALARM_LOCKOUT_EN
    alarm_d  = alarm_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = ENTRY;
          cnt_d   = 3'd1;
          mism_d  = digit_bad;
        end
      end
      ENTRY: begin
        if (key_cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
          mism_d  = 1'b0;
        end else if (key_confirm) begin
          cnt_d  = '0;
          mism_d = 1'b0;
          if (cnt_q == 3'd6 && !mism_q) begin
            state_d  = OPEN;
            unlock_d = 1'b1;
            err_d    = '0;
            timer_d  = TW'(OPEN_CYCLES - 1);
          end else begin
            state_d = IDLE;
            err_d   = err_inc;
`ifdef ALARM_LOCKOUT_EN
            if (err_inc == 2'd3) begin
              state_d = LOCKOUT;
              alarm_d = 1'b1;
              timer_d = TW'(LOCK_CYCLES - 1);
            end
`endif
          end
        end else if (key_valid) begin
          if (cnt_q != 3'd6) cnt_d = cnt_q + 3'd1;
          if (digit_bad) mism_d = 1'b1;
        end
      end
      OPEN: begin
        if (timer_q == '0) begin
          state_d  = IDLE;
          unlock_d = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef ALARM_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          alarm_d = 1'b0;
          err_d   = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
      mism_q   <= 1'b0;
      unlock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      mism_q   <= mism_d;
      unlock_q <= unlock_d;
    end
  end

`ifdef ALARM_LOCKOUT_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign unlock    = unlock_q;
  assign err_cnt   = err_q;
  assign digit_cnt = cnt_q;
  assign busy      = (state_q == OPEN) || (state_q == LOCKOUT);

endmodule
